l1_thresh_sequencer: RTL and testbench
======================================

Name: l1_thresh_sequencer

Overview:
- Configuration controller for the L1 beamforming trigger's threshold port.
- Holds a shadow table of per-beam 18-bit thresholds, written by software over a valid/ready interface.
- On commit, streams the table into the trigger one beam per cycle (thresh / one-hot ce), waits a settle interval, then pulses update so every beam switches atomically.
- Sits in the wishbone clock domain, between the register block and the trigger's thresh_i / thresh_ce_i / update_i inputs.

Parameters:
- NBEAMS, 2, number of trigger beams (1..64).
- BEAM_BITS, 6, width of the beam index; must satisfy 2^BEAM_BITS >= NBEAMS.
- DEFAULT_THRESH, 18'h3FFFF, reset value of every table entry (maximum threshold, so nothing triggers).
- SETTLE_CYCLES, 4, idle cycles between the last ce and the update pulse (0..255).

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- wr_valid_i  in  1  table write request.
- wr_ready_o  out  1  write accepted when valid&ready.
- wr_beam_i  in  BEAM_BITS  beam index of the write.
- wr_thresh_i  in  18  threshold value of the write.
- commit_i  in  1  single-cycle commit request.
- clr_err_i  in  1  clears err_o.
- thresh_o  out  18  to trigger thresh_i.
- thresh_ce_o  out  NBEAMS  to trigger thresh_ce_i; one-hot or zero.
- update_o  out  1  to trigger update_i; one-cycle pulse.
- busy_o  out  1  sequence in progress.
- done_o  out  1  one-cycle pulse at end of sequence.
- err_o  out  1  sticky error: an out-of-range beam write occurred.
- commit_count_o  out  16  number of completed updates.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; all table entries = DEFAULT_THRESH; pending = 0.
  - thresh_o = 0, thresh_ce_o = 0, update_o = 0, busy_o = 0, done_o = 0, err_o = 0, commit_count_o = 0; wr_ready_o = 1 once out of reset.
- Reset mid-sequence: abort immediately. No further ce or update is issued; the table returns to defaults.
- Outputs: all registered except wr_ready_o, which is combinational: wr_ready_o = (state == IDLE).
- Writes:
  - Accepted on valid&ready; the entry updates at that edge.
  - If wr_beam_i >= NBEAMS, the write is accepted and dropped, and err_o is set.
  - clr_err_i clears err_o; if set and clear happen in the same cycle, set wins.
  - Writes are stalled (ready low) in every non-IDLE state.
- FSM states: IDLE, LOAD, SETTLE, UPDATE, DONE.
  - IDLE: commit_i=1 -> LOAD, with idx = 0. A write accepted in the same cycle as commit is included in that commit.
  - LOAD: thresh_o = table[idx] and thresh_ce_o = 1<<idx, both registered. Increment idx. After idx = NBEAMS-1, go to SETTLE, or to UPDATE if SETTLE_CYCLES = 0.
  - SETTLE: thresh_ce_o = 0, thresh_o holds its last value. Count SETTLE_CYCLES cycles, then go to UPDATE.
  - UPDATE: update_o = 1 for exactly one cycle; commit_count_o increments (wraps 0xFFFF -> 0). Go to DONE.
  - DONE: done_o = 1 for one cycle. If pending = 1, clear pending and go to LOAD with idx = 0; otherwise go to IDLE.
- busy_o = 1 in LOAD, SETTLE, UPDATE and DONE.
- commit_i while not IDLE sets pending. Multiple commits coalesce into one. A commit in the DONE cycle also sets pending and is honoured.
- Timing, with commit sampled at edge t0:
  - thresh_ce_o[k] high in cycle t0+1+k.
  - update_o high at t0+NBEAMS+SETTLE_CYCLES+1.
  - done_o high one cycle later.
  - wr_ready_o returns high the cycle after DONE when nothing is pending.

Test Plan:
1. Reset, then commit with no writes (NBEAMS=2, SETTLE=4) -> thresh_o = 0x3FFFF with ce = 01 at t0+1 and ce = 10 at t0+2; update_o at t0+7; done_o at t0+8; commit_count_o = 1.
2. Write beam0 = 0x00123 and beam1 = 0x0ABCD, then commit -> ce cycles carry those values in order; ce is one-hot and update fires exactly once.
3. Write with wr_beam_i = 5 -> accepted and table unchanged; err_o = 1; clr_err_i clears it; clr_err_i together with another bad write leaves err_o = 1.
4. Three commit_i pulses during LOAD/SETTLE -> exactly two full sequences back to back (DONE goes straight to LOAD, second ce[0] one cycle after done_o); commit_count_o = 2.
5. Assert wb_rst_i asynchronously during SETTLE -> outputs reach their reset values without a clock edge; no update_o; the next commit loads 0x3FFFF.
6. Hold wr_valid_i during a sequence -> wr_ready_o = 0 until after DONE; the write lands in IDLE; SETTLE_CYCLES=0 build gives update_o at t0+NBEAMS+1.

Source files
------------

// File: rtl/l1_thresh_sequencer_if.sv
// Software-side write/commit channel and trigger threshold port of l1_thresh_sequencer.
interface l1_thresh_sequencer_if #(
    parameter int NBEAMS    = 2,
    parameter int BEAM_BITS = 6
);
    logic                 wr_valid_i;
    logic                 wr_ready_o;
    logic [BEAM_BITS-1:0] wr_beam_i;
    logic [17:0]          wr_thresh_i;
    logic                 commit_i;
    logic                 clr_err_i;
    logic [17:0]          thresh_o;
    logic [NBEAMS-1:0]    thresh_ce_o;
    logic                 update_o;
    logic                 busy_o;
    logic                 done_o;
    logic                 err_o;
    logic [15:0]          commit_count_o;

    modport master (
        output wr_valid_i, wr_beam_i, wr_thresh_i, commit_i, clr_err_i,
        input  wr_ready_o, thresh_o, thresh_ce_o, update_o, busy_o, done_o, err_o,
               commit_count_o
    );

    modport slave (
        input  wr_valid_i, wr_beam_i, wr_thresh_i, commit_i, clr_err_i,
        output wr_ready_o, thresh_o, thresh_ce_o, update_o, busy_o, done_o, err_o,
               commit_count_o
    );
endinterface

// File: rtl/l1_thresh_sequencer.sv
// Shadow threshold table for the L1 trigger; on commit streams it out one beam per
// cycle, waits a settle interval, then pulses update so all beams switch together.
module l1_thresh_sequencer #(
    parameter int          NBEAMS         = 2,
    parameter int          BEAM_BITS      = 6,
    parameter logic [17:0] DEFAULT_THRESH = 18'h3FFFF,
    parameter int          SETTLE_CYCLES  = 4
) (
    input logic                  wb_clk_i,
    input logic                  wb_rst_i,
    l1_thresh_sequencer_if.slave bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_UPDATE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]           state;
    logic [2:0]           state_next;
    logic [BEAM_BITS-1:0] idx;
    logic [7:0]           settle_cnt;
    logic                 pending;
    logic [17:0]          tbl [NBEAMS];

    logic [17:0]       thresh;
    logic [NBEAMS-1:0] thresh_ce;
    logic              update;
    logic              busy;
    logic              done;
    logic              err;
    logic [15:0]       commit_count;

    logic              wr_ready;
    logic              wr_fire;
    logic              beam_ok;
    logic              last_beam;
    logic              settle_last;
    logic [17:0]       cur_thresh;
    logic [NBEAMS-1:0] cur_onehot;

    assign wr_ready    = (state == S_IDLE);
    assign wr_fire     = bus.wr_valid_i && wr_ready;
    assign beam_ok     = (int'(bus.wr_beam_i) < NBEAMS);
    assign last_beam   = (int'(idx) == NBEAMS - 1);
    assign settle_last = (int'(settle_cnt) == SETTLE_CYCLES - 1);

    // Table read and ce decode as loops so the index width never has to match log2(NBEAMS).
    always_comb begin
        cur_thresh = '0;
        cur_onehot = '0;
        for (int b = 0; b < NBEAMS; b++) begin
            if (int'(idx) == b) begin
                cur_thresh    = tbl[b];
                cur_onehot[b] = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (bus.commit_i) state_next = S_LOAD;
            S_LOAD:   if (last_beam) state_next = (SETTLE_CYCLES == 0) ? S_UPDATE : S_SETTLE;
            S_SETTLE: if (settle_last) state_next = S_UPDATE;
            S_UPDATE: state_next = S_DONE;
            S_DONE:   state_next = (pending || bus.commit_i) ? S_LOAD : S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state        <= S_IDLE;
            idx          <= '0;
            settle_cnt   <= '0;
            pending      <= 1'b0;
            thresh       <= '0;
            thresh_ce    <= '0;
            update       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            commit_count <= '0;
            for (int b = 0; b < NBEAMS; b++) tbl[b] <= DEFAULT_THRESH;
        end else begin
            state      <= state_next;
            busy       <= (state_next != S_IDLE);
            idx        <= (state == S_LOAD) ? idx + 1'b1 : '0;
            settle_cnt <= (state == S_SETTLE) ? settle_cnt + 8'd1 : 8'd0;
            thresh_ce  <= (state == S_LOAD) ? cur_onehot : '0;
            update     <= (state == S_UPDATE);
            done       <= (state == S_DONE);
            if (state == S_LOAD) thresh <= cur_thresh;
            if (state == S_UPDATE) commit_count <= commit_count + 16'd1;

            // DONE consumes the pending request (and any commit arriving that cycle).
            if (state == S_DONE) pending <= 1'b0;
            else if (state != S_IDLE && bus.commit_i) pending <= 1'b1;

            if (wr_fire && beam_ok) begin
                for (int b = 0; b < NBEAMS; b++) begin
                    if (int'(bus.wr_beam_i) == b) tbl[b] <= bus.wr_thresh_i;
                end
            end

            if (wr_fire && !beam_ok) err <= 1'b1;
            else if (bus.clr_err_i) err <= 1'b0;
        end
    end

    assign bus.wr_ready_o     = wr_ready;
    assign bus.thresh_o       = thresh;
    assign bus.thresh_ce_o    = thresh_ce;
    assign bus.update_o       = update;
    assign bus.busy_o         = busy;
    assign bus.done_o         = done;
    assign bus.err_o          = err;
    assign bus.commit_count_o = commit_count;
endmodule

// File: tb/tb_l1_thresh_sequencer.sv
// Directed bench for l1_thresh_sequencer: a settle=4 instance and a settle=0 instance.
module tb_l1_thresh_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt_a = 0;

    always #5 clk = ~clk;

    l1_thresh_sequencer_if #(.NBEAMS(2), .BEAM_BITS(6)) bus_a ();
    l1_thresh_sequencer_if #(.NBEAMS(2), .BEAM_BITS(6)) bus_b ();

    l1_thresh_sequencer #(.NBEAMS(2), .BEAM_BITS(6), .DEFAULT_THRESH(18'h3FFFF),
                          .SETTLE_CYCLES(4)) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .bus(bus_a.slave));

    l1_thresh_sequencer #(.NBEAMS(2), .BEAM_BITS(6), .DEFAULT_THRESH(18'h3FFFF),
                          .SETTLE_CYCLES(0)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .bus(bus_b.slave));

    typedef struct {
        logic        valid;
        logic [5:0]  beam;
        logic [17:0] val;
        logic        clr;
        logic        exp_err;
    } wr_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic get_out(input bit sel, output logic [17:0] th, output logic [1:0] ce,
                           output logic up, output logic dn, output logic rdy,
                           output logic bsy, output logic [15:0] cnt);
        if (sel) begin
            th = bus_b.thresh_o; ce = bus_b.thresh_ce_o; up = bus_b.update_o;
            dn = bus_b.done_o; rdy = bus_b.wr_ready_o; bsy = bus_b.busy_o;
            cnt = bus_b.commit_count_o;
        end else begin
            th = bus_a.thresh_o; ce = bus_a.thresh_ce_o; up = bus_a.update_o;
            dn = bus_a.done_o; rdy = bus_a.wr_ready_o; bsy = bus_a.busy_o;
            cnt = bus_a.commit_count_o;
        end
    endtask

    // One commit from IDLE, checked cycle by cycle against the expected timeline.
    task automatic check_seq(input bit sel, input logic [17:0] e0, input logic [17:0] e1,
                             input int settle, input logic [15:0] exp_cnt);
        logic [17:0] th;
        logic [1:0]  ce;
        logic        up, dn, rdy, bsy;
        logic [15:0] cnt;
        logic [1:0]  exp_ce;
        if (sel) bus_b.commit_i = 1'b1; else bus_a.commit_i = 1'b1;
        tick();
        bus_a.commit_i = 1'b0;
        bus_b.commit_i = 1'b0;
        get_out(sel, th, ce, up, dn, rdy, bsy, cnt);
        chk("t0_busy", 32'(bsy), 32'd1);
        chk("t0_ready", 32'(rdy), 32'd0);
        for (int c = 1; c <= 2 + settle + 2; c++) begin
            tick();
            get_out(sel, th, ce, up, dn, rdy, bsy, cnt);
            exp_ce = (c == 1) ? 2'b01 : (c == 2) ? 2'b10 : 2'b00;
            chk("seq_ce", 32'(ce), 32'(exp_ce));
            chk("seq_thresh", 32'(th), 32'((c == 1) ? e0 : e1));
            chk("seq_update", 32'(up), 32'(c == 2 + settle + 1));
            chk("seq_done", 32'(dn), 32'(c == 2 + settle + 2));
        end
        chk("end_ready", 32'(rdy), 32'd1);
        chk("end_busy", 32'(bsy), 32'd0);
        chk("end_count", 32'(cnt), 32'(exp_cnt));
    endtask

    initial begin
        wr_vec_t vecs [9];
        logic [1:0] exp_ce;

        vecs[0] = '{1'b1, 6'd0, 18'h00123, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 6'd1, 18'h0ABCD, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 6'd5, 18'h00001, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 6'd0, 18'h00000, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 6'd5, 18'h00002, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 6'd0, 18'h00000, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 6'd0, 18'h00000, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 6'd2, 18'h00003, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 6'd0, 18'h00000, 1'b1, 1'b0};

        rst = 1'b1;
        bus_a.wr_valid_i = 1'b0; bus_a.wr_beam_i = '0; bus_a.wr_thresh_i = '0;
        bus_a.commit_i = 1'b0;   bus_a.clr_err_i = 1'b0;
        bus_b.wr_valid_i = 1'b0; bus_b.wr_beam_i = '0; bus_b.wr_thresh_i = '0;
        bus_b.commit_i = 1'b0;   bus_b.clr_err_i = 1'b0;

        // Reset state
        #3;
        chk("rst_thresh", 32'(bus_a.thresh_o), 32'd0);
        chk("rst_ce", 32'(bus_a.thresh_ce_o), 32'd0);
        chk("rst_update", 32'(bus_a.update_o), 32'd0);
        chk("rst_busy", 32'(bus_a.busy_o), 32'd0);
        chk("rst_done", 32'(bus_a.done_o), 32'd0);
        chk("rst_err", 32'(bus_a.err_o), 32'd0);
        chk("rst_count", 32'(bus_a.commit_count_o), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("rst_ready", 32'(bus_a.wr_ready_o), 32'd1);

        // Commit with defaults
        exp_cnt_a = 1;
        check_seq(1'b0, 18'h3FFFF, 18'h3FFFF, 4, 16'(exp_cnt_a));

        // Table-driven writes: good writes, out-of-range writes, clear/set priority
        for (int i = 0; i < 9; i++) begin
            bus_a.wr_valid_i  = vecs[i].valid;
            bus_a.wr_beam_i   = vecs[i].beam;
            bus_a.wr_thresh_i = vecs[i].val;
            bus_a.clr_err_i   = vecs[i].clr;
            chk("vec_ready", 32'(bus_a.wr_ready_o), 32'd1);
            tick();
            bus_a.wr_valid_i = 1'b0;
            bus_a.clr_err_i  = 1'b0;
            chk($sformatf("vec%0d_err", i), 32'(bus_a.err_o), 32'(vecs[i].exp_err));
        end
        exp_cnt_a = 2;
        check_seq(1'b0, 18'h00123, 18'h0ABCD, 4, 16'(exp_cnt_a));

        // Three commits during a sequence coalesce into one back-to-back rerun
        bus_a.commit_i = 1'b1;
        tick();
        bus_a.commit_i = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            tick();
            bus_a.commit_i = 1'b0;
            exp_ce = (c == 1 || c == 9) ? 2'b01 : (c == 2 || c == 10) ? 2'b10 : 2'b00;
            chk("b2b_ce", 32'(bus_a.thresh_ce_o), 32'(exp_ce));
            chk("b2b_update", 32'(bus_a.update_o), 32'(c == 7 || c == 15));
            chk("b2b_done", 32'(bus_a.done_o), 32'(c == 8 || c == 16));
            if (c == 1 || c == 3 || c == 5) bus_a.commit_i = 1'b1;
        end
        exp_cnt_a = 4;
        chk("b2b_ready", 32'(bus_a.wr_ready_o), 32'd1);
        chk("b2b_count", 32'(bus_a.commit_count_o), 32'(exp_cnt_a));

        // Write held during a sequence stalls until the cycle after DONE
        bus_a.commit_i = 1'b1;
        tick();
        bus_a.commit_i    = 1'b0;
        bus_a.wr_valid_i  = 1'b1;
        bus_a.wr_beam_i   = 6'd0;
        bus_a.wr_thresh_i = 18'h11111;
        chk("hold_ready_t0", 32'(bus_a.wr_ready_o), 32'd0);
        for (int c = 1; c <= 8; c++) begin
            tick();
            chk("hold_ready", 32'(bus_a.wr_ready_o), 32'(c == 8));
        end
        tick();
        bus_a.wr_valid_i = 1'b0;
        exp_cnt_a = 5;
        chk("hold_count", 32'(bus_a.commit_count_o), 32'(exp_cnt_a));
        exp_cnt_a = 6;
        check_seq(1'b0, 18'h11111, 18'h0ABCD, 4, 16'(exp_cnt_a));

        // Zero settle interval
        check_seq(1'b1, 18'h3FFFF, 18'h3FFFF, 0, 16'd1);

        // Asynchronous reset during SETTLE aborts the sequence
        bus_a.commit_i = 1'b1;
        tick();
        bus_a.commit_i = 1'b0;
        repeat (3) tick();
        chk("pre_rst_busy", 32'(bus_a.busy_o), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(bus_a.busy_o), 32'd0);
        chk("arst_thresh", 32'(bus_a.thresh_o), 32'd0);
        chk("arst_count", 32'(bus_a.commit_count_o), 32'd0);
        chk("arst_ce", 32'(bus_a.thresh_ce_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("arst_no_update", 32'(bus_a.update_o), 32'd0);
            chk("arst_ready", 32'(bus_a.wr_ready_o), 32'd1);
        end
        exp_cnt_a = 1;
        check_seq(1'b0, 18'h3FFFF, 18'h3FFFF, 4, 16'(exp_cnt_a));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
